// File: rtl/wm_raster_writer_if.sv
// Frame-buffer write port: address/data/request toward memory, ready back.
interface wm_raster_writer_if #(
  parameter int unsigned AW = 21,
  parameter int unsigned DW = 8
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_ready;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_ready);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_ready);
endinterface

// File: rtl/wm_raster_writer.sv
// Restores raster order for a block-ordered pixel stream and writes it through a FIFO.
// Optional WM_CHECKSUM_EN: 16-bit wrap-around sum of every completed write.
module wm_raster_writer #(
  parameter int unsigned Data_Depth      = 8,
  parameter int unsigned Amba_Addr_Depth = 20,
  parameter int unsigned Dim_Depth       = 10,
  parameter int unsigned Block_Depth     = 7,
  parameter int unsigned Fifo_Depth      = 16,
  parameter int unsigned Fifo_Ptr        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [Dim_Depth-1:0]     Np,
  input  logic [7:0]               M,
  input  logic [Amba_Addr_Depth:0] out_base,
  input  logic [Data_Depth-1:0]    Pixel_Data,
  input  logic                     new_pixel,
  wm_raster_writer_if.master       mem,
  output logic                     fifo_full,
  output logic                     overflow,
  output logic                     frame_done,
  output logic [15:0]              checksum
);
  localparam int unsigned AW = Amba_Addr_Depth + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  logic [Dim_Depth-1:0]   np_q, m_dim, bx, by;
  logic [Block_Depth-1:0] m_last, col, row;
  logic [AW-1:0]          base_q;

  logic [AW-1:0]         addr_mem [Fifo_Depth];
  logic [Data_Depth-1:0] data_mem [Fifo_Depth];
  logic [Fifo_Ptr-1:0]   wr_ptr, rd_ptr;
  logic [Fifo_Ptr:0]     count, count_nxt;

  logic take, push, pop;
  logic col_wrap, row_wrap, bx_wrap, by_wrap;
  logic [2*Dim_Depth-1:0] prod;
  logic [AW-1:0]          pix_addr;

  assign fifo_full     = (count == (Fifo_Ptr+1)'(Fifo_Depth));
  assign mem.mem_we    = (count != '0);
  // Head is masked while empty so the port reads all-zero after reset.
  assign mem.mem_addr  = mem.mem_we ? addr_mem[rd_ptr] : '0;
  assign mem.mem_wdata = mem.mem_we ? data_mem[rd_ptr] : '0;

  always_comb begin
    take     = (state == RUN) && new_pixel;
    pop      = mem.mem_we && mem.mem_ready;
    push     = take && (!fifo_full || pop);
    col_wrap = (col == m_last);
    row_wrap = (row == m_last);
    bx_wrap  = ((bx + m_dim) == np_q);
    by_wrap  = ((by + m_dim) == np_q);
    prod     = (2*Dim_Depth)'(by + Dim_Depth'(row)) * (2*Dim_Depth)'(np_q);
    pix_addr = base_q + AW'(prod) + AW'(bx) + AW'(col);
    count_nxt = count;
    if (push && !pop)      count_nxt = count + (Fifo_Ptr+1)'(1);
    else if (pop && !push) count_nxt = count - (Fifo_Ptr+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= pix_addr;
      data_mem[wr_ptr] <= Pixel_Data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      np_q       <= '0;
      m_dim      <= '0;
      m_last     <= '0;
      base_q     <= '0;
      col        <= '0;
      row        <= '0;
      bx         <= '0;
      by         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + Fifo_Ptr'(1);
      if (pop)  rd_ptr <= rd_ptr + Fifo_Ptr'(1);
      count <= count_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            np_q       <= Np;
            m_dim      <= Dim_Depth'(M);
            m_last     <= Block_Depth'(M - 8'd1);
            base_q     <= out_base;
            col        <= '0;
            row        <= '0;
            bx         <= '0;
            by         <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (take) begin
            // Dropped pixels still advance the scan so later addresses stay correct.
            if (!push) overflow <= 1'b1;
            if (!col_wrap) col <= col + Block_Depth'(1);
            else begin
              col <= '0;
              if (!row_wrap) row <= row + Block_Depth'(1);
              else begin
                row <= '0;
                if (!bx_wrap) bx <= bx + m_dim;
                else begin
                  bx <= '0;
                  if (!by_wrap) by <= by + m_dim;
                  else begin
                    by    <= '0;
                    state <= DRAIN;
                  end
                end
              end
            end
          end
        end
        DRAIN: begin
          if (count_nxt == '0) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WM_CHECKSUM_EN
  logic [15:0] sum;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                            sum <= '0;
    else if (start && (state == IDLE || state == DONE)) sum <= '0;
    else if (pop)                                        sum <= sum + 16'(mem.mem_wdata);
  end
  assign checksum = sum;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_wm_raster_writer.sv
// Scoreboard bench for wm_raster_writer: expected writes queued on drive, checked on handshake.
module tb_wm_raster_writer;
  localparam int unsigned AW = 21;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          new_pixel = 1'b0;
  logic [9:0]    Np = '0;
  logic [7:0]    M = '0;
  logic [AW-1:0] out_base = '0;
  logic [DW-1:0] Pixel_Data = '0;
  logic          fifo_full, overflow, frame_done;
  logic [15:0]   checksum;

  wm_raster_writer_if #(.AW(AW), .DW(DW)) mem ();

  wm_raster_writer #(
    .Data_Depth(8), .Amba_Addr_Depth(20), .Dim_Depth(10),
    .Block_Depth(7), .Fifo_Depth(16), .Fifo_Ptr(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .Np(Np), .M(M), .out_base(out_base),
    .Pixel_Data(Pixel_Data), .new_pixel(new_pixel), .mem(mem),
    .fifo_full(fifo_full), .overflow(overflow), .frame_done(frame_done),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [DW-1:0] data; logic [AW-1:0] addr; } vec_t;

  wr_t           sb[$];
  int unsigned   n_checks = 0;
  int unsigned   n_pass = 0;
  logic [AW-1:0] last_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Inspect the write port for the coming edge, then advance one cycle.
  task automatic tick();
    wr_t e;
    if (mem.mem_we === 1'b1 && mem.mem_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr 0x%0h required none", mem.mem_addr);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(mem.mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem.mem_wdata), 32'(e.data));
        last_addr = mem.mem_addr;
      end
    end else if (mem.mem_we === 1'b1 && sb.size() != 0) begin
      check("stall_addr", 32'(mem.mem_addr), 32'(sb[0].addr));
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] model_addr(input int unsigned idx, input int unsigned np,
                                               input int unsigned m, input int unsigned base);
    int unsigned bpr, blk, inb;
    bpr = np / m;
    blk = idx / (m * m);
    inb = idx % (m * m);
    return AW'(base + ((blk / bpr) * m + inb / m) * np + (blk % bpr) * m + inb % m);
  endfunction

  task automatic drive_pixel(input logic [DW-1:0] d, input logic acc, input logic [AW-1:0] a);
    Pixel_Data = d;
    new_pixel  = 1'b1;
    if (acc) sb.push_back('{addr: a, data: d});
    tick();
    new_pixel = 1'b0;
  endtask

  task automatic do_start(input logic [9:0] np, input logic [7:0] m, input logic [AW-1:0] base);
    Np = np; M = m; out_base = base; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sb.delete();
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int unsigned budget, input string name);
    for (int unsigned i = 0; i < budget; i++) begin
      if (frame_done === 1'b1) break;
      tick();
    end
    check(name, 32'(frame_done), 32'd1);
  endtask

  task automatic drain(input int unsigned budget, input string name);
    for (int unsigned i = 0; i < budget; i++) begin
      if (mem.mem_we !== 1'b1) break;
      tick();
    end
    check({name, "_we"}, 32'(mem.mem_we), 32'd0);
    check({name, "_sb"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_we"},    32'(mem.mem_we), 32'd0);
    check({name, "_addr"},  32'(mem.mem_addr), 32'd0);
    check({name, "_wdata"}, 32'(mem.mem_wdata), 32'd0);
    check({name, "_full"},  32'(fifo_full), 32'd0);
    check({name, "_ovf"},   32'(overflow), 32'd0);
    check({name, "_done"},  32'(frame_done), 32'd0);
    check({name, "_csum"},  32'(checksum), 32'd0);
  endtask

  initial begin
    vec_t        tbl [16];
    logic [15:0] exp_csum;

    tbl = '{'{8'd0,  21'h100}, '{8'd1,  21'h101}, '{8'd2,  21'h104}, '{8'd3,  21'h105},
            '{8'd4,  21'h102}, '{8'd5,  21'h103}, '{8'd6,  21'h106}, '{8'd7,  21'h107},
            '{8'd8,  21'h108}, '{8'd9,  21'h109}, '{8'd10, 21'h10C}, '{8'd11, 21'h10D},
            '{8'd12, 21'h10A}, '{8'd13, 21'h10B}, '{8'd14, 21'h10E}, '{8'd15, 21'h10F}};
    mem.mem_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    tick();
    check("post_reset_we", 32'(mem.mem_we), 32'd0);

    // Raster reorder, Np=4 M=2, table-driven
    mem.mem_ready = 1'b1;
    do_start(10'd4, 8'd2, 21'h100);
    for (int unsigned i = 0; i < 16; i++) drive_pixel(tbl[i].data, 1'b1, tbl[i].addr);
    check("done_early", 32'(frame_done), 32'd0);
    tick();
    check("done_17", 32'(frame_done), 32'd1);
    check("t1_we_idle", 32'(mem.mem_we), 32'd0);
`ifdef WM_CHECKSUM_EN
    exp_csum = 16'h0078;
`else
    exp_csum = 16'h0000;
`endif
    check("t1_csum", 32'(checksum), 32'(exp_csum));

    // All-0xFF frame restarted from DONE
    do_start(10'd4, 8'd2, 21'h000);
    check("restart_clears_done", 32'(frame_done), 32'd0);
    for (int unsigned i = 0; i < 16; i++) drive_pixel(8'hFF, 1'b1, model_addr(i, 4, 2, 0));
    wait_done(40, "ff_done");
`ifdef WM_CHECKSUM_EN
    exp_csum = 16'h0FF0;
`else
    exp_csum = 16'h0000;
`endif
    check("ff_csum", 32'(checksum), 32'(exp_csum));

    // Overflow: 20 pixels into a stalled port, last 4 dropped
    do_reset();
    mem.mem_ready = 1'b0;
    do_start(10'd8, 8'd4, 21'h200);
    for (int unsigned i = 0; i < 20; i++)
      drive_pixel(8'(i + 8'h30), i < 16, model_addr(i, 8, 4, 'h200));
    check("ovf_full", 32'(fifo_full), 32'd1);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_we", 32'(mem.mem_we), 32'd1);
    tick();
    mem.mem_ready = 1'b1;
    drain(40, "ovf_drain");
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous push and pop: nothing dropped
    do_reset();
    mem.mem_ready = 1'b0;
    do_start(10'd8, 8'd4, 21'h300);
    for (int unsigned i = 0; i < 16; i++) drive_pixel(8'(i), 1'b1, model_addr(i, 8, 4, 'h300));
    check("pp_full_before", 32'(fifo_full), 32'd1);
    mem.mem_ready = 1'b1;
    drive_pixel(8'd16, 1'b1, model_addr(16, 8, 4, 'h300));
    mem.mem_ready = 1'b0;
    check("pp_full_after", 32'(fifo_full), 32'd1);
    check("pp_no_ovf", 32'(overflow), 32'd0);
    mem.mem_ready = 1'b1;
    drain(40, "pp_drain");

    // Mid-frame reset, then a clean frame that ignores a start while running
    do_reset();
    do_start(10'd4, 8'd2, 21'h000);
    for (int unsigned i = 0; i < 5; i++) drive_pixel(8'(i + 1), 1'b1, model_addr(i, 4, 2, 0));
    rst = 1'b0;
    sb.delete();
    #1;
    check_all_zero("midrst");
    tick();
    check_all_zero("midrst_cyc");
    #2;
    rst = 1'b1;
    tick();
    check("midrst_release_we", 32'(mem.mem_we), 32'd0);
    do_start(10'd4, 8'd2, 21'h040);
    for (int unsigned i = 0; i < 16; i++) begin
      if (i == 3) begin
        start = 1'b1; Np = 10'd8; M = 8'd4; out_base = 21'h999;
      end
      drive_pixel(8'(i + 8'h50), 1'b1, model_addr(i, 4, 2, 'h40));
      start = 1'b0;
    end
    wait_done(40, "clean_done");
    check("clean_last_addr", 32'(last_addr), 32'h04F);

    // Large blocks: Np=144, M=72
    do_reset();
    mem.mem_ready = 1'b1;
    do_start(10'd144, 8'd72, 21'h000);
    for (int unsigned i = 0; i < 144 * 144; i++) drive_pixel(8'(i), 1'b1, model_addr(i, 144, 72, 0));
    wait_done(40, "big_done");
    check("big_last_addr", 32'(last_addr), 32'd20735);
    check("big_no_ovf", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
